// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
// Purpose: carries every handshake and data wire around the shared ALU.
// That is both request channels, the operand/result wires to the ALU and
// the response channel. The arbiter uses the slave modport. The requester,
// ALU and response-consumer side uses the master modport.
// Signals:
//   req{0,1}_valid/ready      request handshake per requester
//   req{0,1}_a/b/op/shamt     operands, ALUOp code and shift amount
//   alu_a/b/op/shamt          operands presented to the ALU
//   alu_c/alu_zero            ALU result and Zero flag
//   rsp_valid/ready           response handshake
//   rsp_id/c/zero             owner, captured result, captured Zero

interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [3:0]       req0_op;
    logic [4:0]       req0_shamt;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [3:0]       req1_op;
    logic [4:0]       req1_shamt;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_op;
    logic [4:0]       alu_shamt;
    logic [WIDTH-1:0] alu_c;
    logic             alu_zero;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_c;
    logic             rsp_zero;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op, req0_shamt,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op, req1_shamt,
        output req1_ready,
        output alu_a, alu_b, alu_op, alu_shamt,
        input  alu_c, alu_zero,
        output rsp_valid, rsp_id, rsp_c, rsp_zero,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op, req0_shamt,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op, req1_shamt,
        input  req1_ready,
        input  alu_a, alu_b, alu_op, alu_shamt,
        output alu_c, alu_zero,
        input  rsp_valid, rsp_id, rsp_c, rsp_zero,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Purpose: shares one combinational ALU between requester 0 (the EX-stage
// datapath) and requester 1 (an auxiliary unit). Access is granted round
// robin. The granted operands are registered and held on the ALU for
// EXEC_CYCLES cycles. The result and Zero flag are then captured and
// returned along with the owning requester's ID.
// Ports:
//   clk   rising-edge clock
//   rstn  asynchronous active-low reset
//   bus   alu_arbiter_if.slave: both request channels, the ALU operand and
//         result wires, and the response channel

module alu_arbiter #(
    parameter int         WIDTH       = 32,
    parameter int         EXEC_CYCLES = 1,
    parameter logic [3:0] ALU_NOP     = 4'b0000
) (
    input logic          clk,
    input logic          rstn,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int               CNT_W    = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

    // A zero-cycle hold would capture the ALU output before the operands reach it.
    generate
        if (EXEC_CYCLES < 1) begin : g_exec_cycles_check
            $error("alu_arbiter: EXEC_CYCLES must be at least 1");
        end
    endgenerate

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;
    logic             cur_id;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [3:0]       op_reg;
    logic [4:0]       shamt_reg;
    logic             rsp_valid_reg;
    logic             rsp_id_reg;
    logic [WIDTH-1:0] rsp_c_reg;
    logic             rsp_zero_reg;
    logic             grant_valid;
    logic             grant_id;
    logic             exec_last;

    // Round-robin pick. It is only live in IDLE, and it is gated by rstn so
    // that no ready can leak out while reset is held. When both requesters
    // are valid, the one that did not win last time gets the grant.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (state == IDLE && rstn) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = ~last_grant;
            end else if (bus.req0_valid) begin
                grant_valid = 1'b1;
            end else if (bus.req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    assign exec_last = (state == EXEC) && (cnt == CNT_LAST);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A grant is also the handshake, because the
    // requester's valid is already part of the grant condition.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid)   state_next = EXEC;
            EXEC:    if (exec_last)     state_next = DONE;
            DONE:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs. The ALU sees the real opcode only in EXEC; at all other
    // times it sees a NOP. The operand wires keep the last granted values
    // so that they do not toggle between operations.
    always_comb begin
        bus.req0_ready = grant_valid && !grant_id;
        bus.req1_ready = grant_valid && grant_id;
        bus.alu_op     = (state == EXEC) ? op_reg : ALU_NOP;
        bus.alu_a      = a_reg;
        bus.alu_b      = b_reg;
        bus.alu_shamt  = shamt_reg;
        bus.rsp_valid  = rsp_valid_reg;
        bus.rsp_id     = rsp_id_reg;
        bus.rsp_c      = rsp_c_reg;
        bus.rsp_zero   = rsp_zero_reg;
    end

    // Operand latch, hold counter and response capture. The response
    // registers are written only on the last EXEC cycle, so they stay
    // stable for as long as the consumer stalls in DONE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt           <= '0;
            last_grant    <= 1'b1;
            cur_id        <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            op_reg        <= ALU_NOP;
            shamt_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= 1'b0;
            rsp_c_reg     <= '0;
            rsp_zero_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        cur_id     <= grant_id;
                        last_grant <= grant_id;
                        cnt        <= '0;
                        if (grant_id) begin
                            a_reg     <= bus.req1_a;
                            b_reg     <= bus.req1_b;
                            op_reg    <= bus.req1_op;
                            shamt_reg <= bus.req1_shamt;
                        end else begin
                            a_reg     <= bus.req0_a;
                            b_reg     <= bus.req0_b;
                            op_reg    <= bus.req0_op;
                            shamt_reg <= bus.req0_shamt;
                        end
                    end
                end
                EXEC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (exec_last) begin
                        rsp_c_reg     <= bus.alu_c;
                        rsp_zero_reg  <= bus.alu_zero;
                        rsp_id_reg    <= cur_id;
                        rsp_valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Purpose: testbench for alu_arbiter. It supplies a behavioural ALU and a
// transaction-level model of the arbiter. The model is checked against the
// DUT on every falling edge. Directed scenarios with hand-computed results
// are followed by a randomized run.

module tb_alu_arbiter;

    localparam int         WIDTH   = 32;
    localparam int         EXEC    = 3;
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(WIDTH)) bus ();

    alu_arbiter #(
        .WIDTH(WIDTH),
        .EXEC_CYCLES(EXEC),
        .ALU_NOP(OP_NOP)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] s);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            OP_SLL:  return b << s;
            OP_SRL:  return b >> s;
            default: return 32'd0;
        endcase
    endfunction

    assign bus.alu_c    = ref_alu(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_shamt);
    assign bus.alu_zero = (bus.alu_c == 32'd0);

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input bit who, input bit valid, input logic [3:0] op,
                                  input logic [31:0] a, input logic [31:0] b, input logic [4:0] s);
        if (who) begin
            bus.req1_valid = valid; bus.req1_op = op; bus.req1_a = a;
            bus.req1_b = b; bus.req1_shamt = s;
        end else begin
            bus.req0_valid = valid; bus.req0_op = op; bus.req0_a = a;
            bus.req0_b = b; bus.req0_shamt = s;
        end
    endtask

    // Transaction model: tracks the operation in flight by the edge on
    // which it was accepted. The expected outputs follow from that edge
    // count and the latency and round-robin rules.
    int unsigned cyc = 0;
    bit          m_busy = 1'b0;
    int unsigned m_issue = 0;
    bit          m_last = 1'b1;
    bit          m_id = 1'b0;
    logic [31:0] m_a = '0, m_b = '0, m_c = '0;
    logic [4:0]  m_s = '0;
    logic [3:0]  m_op = OP_NOP;
    logic        m_rid = 1'b0, m_zero = 1'b0;

    always @(negedge clk) begin
        bit in_exec, has_rsp, g0, g1;
        logic [31:0] rc;
        if (!rstn) begin
            m_busy = 0; m_last = 1; m_id = 0; m_a = 0; m_b = 0; m_s = 0;
            m_op = OP_NOP; m_c = 0; m_zero = 0; m_rid = 0;
            check_output("rst_ready0", 32'(bus.req0_ready), 0);
            check_output("rst_ready1", 32'(bus.req1_ready), 0);
            check_output("rst_alu_op", 32'(bus.alu_op), 32'(OP_NOP));
            check_output("rst_alu_a", bus.alu_a, 0);
            check_output("rst_alu_b", bus.alu_b, 0);
            check_output("rst_alu_shamt", 32'(bus.alu_shamt), 0);
            check_output("rst_rsp_valid", 32'(bus.rsp_valid), 0);
            check_output("rst_rsp_id", 32'(bus.rsp_id), 0);
            check_output("rst_rsp_c", bus.rsp_c, 0);
            check_output("rst_rsp_zero", 32'(bus.rsp_zero), 0);
        end else begin
            in_exec = m_busy && (cyc < m_issue + EXEC);
            has_rsp = m_busy && (cyc >= m_issue + EXEC);
            if (has_rsp && cyc == m_issue + EXEC) begin
                rc = ref_alu(m_op, m_a, m_b, m_s);
                m_c = rc; m_zero = (rc == 0); m_rid = m_id;
            end
            g0 = 0; g1 = 0;
            if (!m_busy) begin
                if (bus.req0_valid && bus.req1_valid) begin
                    g0 = m_last; g1 = !m_last;
                end else begin
                    g0 = bus.req0_valid; g1 = bus.req1_valid;
                end
            end
            check_output("m_ready0", 32'(bus.req0_ready), 32'(g0));
            check_output("m_ready1", 32'(bus.req1_ready), 32'(g1));
            check_output("m_alu_op", 32'(bus.alu_op), in_exec ? 32'(m_op) : 32'(OP_NOP));
            check_output("m_alu_a", bus.alu_a, m_a);
            check_output("m_alu_b", bus.alu_b, m_b);
            check_output("m_alu_shamt", 32'(bus.alu_shamt), 32'(m_s));
            check_output("m_rsp_valid", 32'(bus.rsp_valid), 32'(has_rsp));
            check_output("m_rsp_c", bus.rsp_c, m_c);
            check_output("m_rsp_zero", 32'(bus.rsp_zero), 32'(m_zero));
            check_output("m_rsp_id", 32'(bus.rsp_id), 32'(m_rid));
            if (g0 || g1) begin
                m_busy = 1; m_issue = cyc + 1; m_id = g1; m_last = g1;
                m_a  = g1 ? bus.req1_a : bus.req0_a;
                m_b  = g1 ? bus.req1_b : bus.req0_b;
                m_op = g1 ? bus.req1_op : bus.req0_op;
                m_s  = g1 ? bus.req1_shamt : bus.req0_shamt;
            end else if (has_rsp && bus.rsp_ready) begin
                m_busy = 0;
            end
        end
        cyc++;
    end

    task automatic wait_grant(input bit who);
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = who ? bus.req1_ready : bus.req0_ready;
        end
        if (!got) check_output("grant_timeout", 0, 1);
    endtask

    task automatic wait_rsp(output logic [31:0] c, output logic z, output logic id, output int lat);
        bit got = 0;
        lat = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            got = bus.rsp_valid;
        end
        if (!got) check_output("rsp_timeout", 0, 1);
        c = bus.rsp_c; z = bus.rsp_zero; id = bus.rsp_id;
    endtask

    task automatic run_op(input bit who, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] s,
                          output logic [31:0] c, output logic z, output logic id, output int lat);
        apply_stimulus(who, 1'b1, op, a, b, s);
        wait_grant(who);
        @(posedge clk); #1;
        apply_stimulus(who, 1'b0, op, a, b, s);
        wait_rsp(c, z, id, lat);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] c;
        logic        z, id;
        int          lat;
        logic [31:0] gseq[4], rid[4], rcv[4];
        int          ng, nr;
        bit          both_ready, seen_valid;

        apply_stimulus(0, 0, OP_NOP, 0, 0, 0);
        apply_stimulus(1, 0, OP_NOP, 0, 0, 0);
        bus.rsp_ready = 1'b1;
        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        $display("[TB] reset released");

        // Directed: single ADD on requester 0.
        run_op(0, OP_ADD, 32'd5, 32'd7, 5'd0, c, z, id, lat);
        check_output("add_c", c, 32'd12);
        check_output("add_zero", 32'(z), 0);
        check_output("add_id", 32'(id), 0);
        check_output("add_latency", 32'(lat), EXEC);

        // Directed: requester 1 SUB to zero, then SLL.
        run_op(1, OP_SUB, 32'd3, 32'd3, 5'd0, c, z, id, lat);
        check_output("sub_c", c, 32'd0);
        check_output("sub_zero", 32'(z), 1);
        check_output("sub_id", 32'(id), 1);
        run_op(1, OP_SLL, 32'd0, 32'd1, 5'd4, c, z, id, lat);
        check_output("sll_c", c, 32'd16);
        check_output("sll_id", 32'(id), 1);

        // Both requesters valid from reset: grants alternate, starting with 0.
        @(posedge clk); #1 rstn = 1'b0;
        apply_stimulus(0, 1, OP_ADD, 32'd1, 32'd1, 5'd0);
        apply_stimulus(1, 1, OP_OR, 32'd8, 32'd1, 5'd0);
        @(posedge clk); #1 rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin gseq[k] = 32'hDEAD; rid[k] = 32'hDEAD; rcv[k] = 32'hDEAD; end
        ng = 0; nr = 0; both_ready = 0;
        for (int i = 0; i < 80 && (ng < 4 || nr < 4); i++) begin
            @(negedge clk);
            if (bus.req0_ready && bus.req1_ready) both_ready = 1;
            if (ng < 4 && bus.req0_ready) begin gseq[ng] = 0; ng++; end
            else if (ng < 4 && bus.req1_ready) begin gseq[ng] = 1; ng++; end
            if (nr < 4 && bus.rsp_valid) begin rid[nr] = 32'(bus.rsp_id); rcv[nr] = bus.rsp_c; nr++; end
        end
        for (int k = 0; k < 4; k++) begin
            check_output($sformatf("rr_grant%0d", k), gseq[k], 32'(k % 2));
            check_output($sformatf("rr_rsp_id%0d", k), rid[k], 32'(k % 2));
            check_output($sformatf("rr_rsp_c%0d", k), rcv[k], (k % 2) ? 32'd9 : 32'd2);
        end
        check_output("rr_never_two_ready", 32'(both_ready), 0);
        apply_stimulus(0, 0, OP_NOP, 0, 0, 0);
        apply_stimulus(1, 0, OP_NOP, 0, 0, 0);
        repeat (EXEC + 3) @(posedge clk);
        #1;

        // Response stall: outputs hold, no new grant until rsp_ready.
        bus.rsp_ready = 1'b0;
        run_op(0, OP_ADD, 32'd10, 32'd20, 5'd0, c, z, id, lat);
        apply_stimulus(1, 1, OP_SUB, 32'd9, 32'd4, 5'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_output("stall_valid", 32'(bus.rsp_valid), 1);
            check_output("stall_c", bus.rsp_c, 32'd30);
            check_output("stall_id", 32'(bus.rsp_id), 0);
            check_output("stall_no_ready", 32'(bus.req1_ready), 0);
        end
        @(posedge clk); #1 bus.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_output("stall_regrant", 32'(bus.req1_ready), 1);
        @(posedge clk); #1;
        apply_stimulus(1, 0, OP_SUB, 32'd9, 32'd4, 5'd0);
        wait_rsp(c, z, id, lat);
        check_output("after_stall_c", c, 32'd5);
        check_output("after_stall_id", 32'(id), 1);

        // Reset in the middle of EXEC drops the operation.
        apply_stimulus(0, 1, OP_ADD, 32'd100, 32'd200, 5'd3);
        wait_grant(0);
        @(posedge clk); #1;
        apply_stimulus(0, 0, OP_ADD, 32'd100, 32'd200, 5'd3);
        @(posedge clk); #1;
        check_output("mid_exec_alu_op", 32'(bus.alu_op), 32'(OP_ADD));
        rstn = 1'b0;
        #1;
        check_output("async_rst_alu_op", 32'(bus.alu_op), 32'(OP_NOP));
        check_output("async_rst_alu_a", bus.alu_a, 0);
        check_output("async_rst_alu_shamt", 32'(bus.alu_shamt), 0);
        check_output("async_rst_rsp_valid", 32'(bus.rsp_valid), 0);
        @(posedge clk); #1 rstn = 1'b1;
        seen_valid = 0;
        repeat (EXEC + 6) begin
            @(negedge clk);
            if (bus.rsp_valid) seen_valid = 1;
        end
        check_output("no_replay_after_rst", 32'(seen_valid), 0);

        // Signed and unsigned compares; NOP on the ALU while idle.
        run_op(0, OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0, c, z, id, lat);
        check_output("slt_c", c, 32'd1);
        run_op(1, OP_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd0, c, z, id, lat);
        check_output("sltu_c", c, 32'd0);
        check_output("sltu_zero", 32'(z), 1);
        @(negedge clk); @(negedge clk);
        check_output("idle_alu_op", 32'(bus.alu_op), 32'(OP_NOP));

        // Randomized traffic, checked by the model on every cycle.
        $display("[TB] random phase");
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            for (int r = 0; r < 2; r++) begin
                if ($urandom_range(0, 2) == 0)
                    apply_stimulus(r[0], 1'($urandom_range(0, 1)), 4'($urandom_range(1, 8)),
                                   $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3)),
                                   $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3)),
                                   5'($urandom_range(0, 31)));
            end
        end
        apply_stimulus(0, 0, OP_NOP, 0, 0, 0);
        apply_stimulus(1, 0, OP_NOP, 0, 0, 0);
        repeat (4) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
